// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mc_ctrl_pkg : shared state, opcode, ALU-op and datapath-select encodings
// Revision    : 1.0
// ============================================================================
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI,
    S_MDU_WAIT, S_TRAP
  } state_t;

  typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_R, MODE_I} aluMode_t;

  localparam logic [6:0] c_opLoad    = 7'b0000011;
  localparam logic [6:0] c_opStore   = 7'b0100011;
  localparam logic [6:0] c_opOp      = 7'b0110011;
  localparam logic [6:0] c_opOpImm   = 7'b0010011;
  localparam logic [6:0] c_opBranch  = 7'b1100011;
  localparam logic [6:0] c_opJal     = 7'b1101111;
  localparam logic [6:0] c_opJalr    = 7'b1100111;
  localparam logic [6:0] c_opLui     = 7'b0110111;
  localparam logic [6:0] c_opAuipc   = 7'b0010111;
  localparam logic [6:0] c_funct7Mdu = 7'b0000001;

  localparam logic [3:0] c_aluAdd  = 4'd0;
  localparam logic [3:0] c_aluSub  = 4'd1;
  localparam logic [3:0] c_aluAnd  = 4'd2;
  localparam logic [3:0] c_aluOr   = 4'd3;
  localparam logic [3:0] c_aluXor  = 4'd4;
  localparam logic [3:0] c_aluSlt  = 4'd5;
  localparam logic [3:0] c_aluSltu = 4'd6;
  localparam logic [3:0] c_aluSll  = 4'd7;
  localparam logic [3:0] c_aluSrl  = 4'd8;
  localparam logic [3:0] c_aluSra  = 4'd9;

  localparam logic [1:0] c_srcAPc    = 2'd0;
  localparam logic [1:0] c_srcAOldPc = 2'd1;
  localparam logic [1:0] c_srcARs1   = 2'd2;
  localparam logic [1:0] c_srcAZero  = 2'd3;

  localparam logic [1:0] c_srcBRs2  = 2'd0;
  localparam logic [1:0] c_srcBImm  = 2'd1;
  localparam logic [1:0] c_srcBFour = 2'd2;

  localparam logic [1:0] c_resAluOut = 2'd0;
  localparam logic [1:0] c_resLoad   = 2'd1;
  localparam logic [1:0] c_resAluRes = 2'd2;
  localparam logic [1:0] c_resMdu    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// mc_ctrl_if : control-unit <-> datapath/memory/MDU signal bundle
// Revision   : 1.0
// ============================================================================
interface mc_ctrl_if #(parameter int ALUCTR_W = 4);
  logic [31:0]         instr;
  logic                alu_zero;
  logic                alu_lt;
  logic                alu_ltu;
  logic                mem_ready;
  logic                mdu_done;
  logic                mem_req;
  logic                mem_write;
  logic                adr_src;
  logic                ir_write;
  logic                pc_write;
  logic                reg_write;
  logic [1:0]          result_src;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUCTR_W-1:0] alu_ctr;
  logic                mdu_start;
  logic                illegal;

  modport master (
    input  instr, alu_zero, alu_lt, alu_ltu, mem_ready, mdu_done,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_ctr, mdu_start, illegal
  );

  modport slave (
    output instr, alu_zero, alu_lt, alu_ltu, mem_ready, mdu_done,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_ctr, mdu_start, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm_alu_op_dec.sv
`default_nettype none
// ============================================================================
// alu_op_dec : funct3/funct7[5]/mode -> ALU operation code
// Revision   : 1.0
// ============================================================================
module alu_op_dec
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTR_W = 4
) (
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  aluMode_t            mode,
  output logic [ALUCTR_W-1:0] aluCtr
);

  logic [3:0] w_code;

  always_comb begin
    w_code = c_aluAdd;
    case (mode)
      MODE_ADD: w_code = c_aluAdd;
      MODE_SUB: w_code = c_aluSub;
      default: begin
        case (funct3)
          // Immediate forms reuse bit 30 as immediate data except for shifts
          3'b000: w_code = (mode == MODE_R && funct7b5) ? c_aluSub : c_aluAdd;
          3'b001: w_code = c_aluSll;
          3'b010: w_code = c_aluSlt;
          3'b011: w_code = c_aluSltu;
          3'b100: w_code = c_aluXor;
          3'b101: w_code = funct7b5 ? c_aluSra : c_aluSrl;
          3'b110: w_code = c_aluOr;
          3'b111: w_code = c_aluAnd;
        endcase
      end
    endcase
  end

  assign aluCtr = ALUCTR_W'(w_code);

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// mc_ctrl_fsm : multicycle RV32I main control FSM with integrated ALU decoder
// Revision    : 1.0
// ============================================================================
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int M_EXT    = 0,
  parameter int ALUCTR_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  state_t              r_state;
  state_t              w_stateNext;
  logic                r_illegal;
  logic                r_mduBusy;
  logic                w_memReq;
  logic                w_memWrite;
  logic                w_adrSrc;
  logic                w_irWrite;
  logic                w_pcWrite;
  logic                w_regWrite;
  logic [1:0]          w_resultSrc;
  logic [1:0]          w_srcA;
  logic [1:0]          w_srcB;
  logic                w_mduStart;
  logic                w_taken;
  logic                w_branchOk;
  aluMode_t            w_mode;
  logic [ALUCTR_W-1:0] w_aluCtr;
  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic                w_unusedInstr;

  assign w_opcode      = bus.instr[6:0];
  assign w_funct3      = bus.instr[14:12];
  assign w_funct7      = bus.instr[31:25];
  assign w_unusedInstr = ^{bus.instr[24:15], bus.instr[11:7]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_mduBusy <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_illegal <= r_illegal | (w_stateNext == S_TRAP);
      // Marks MDU_WAIT cycles after the first so mdu_start is a single pulse
      r_mduBusy <= (r_state == S_MDU_WAIT) && (w_stateNext == S_MDU_WAIT);
    end
  end

  always_comb begin
    w_taken    = 1'b0;
    w_branchOk = 1'b1;
    case (w_funct3)
      3'b000:  w_taken = bus.alu_zero;
      3'b001:  w_taken = !bus.alu_zero;
      3'b100:  w_taken = bus.alu_lt;
      3'b101:  w_taken = !bus.alu_lt;
      3'b110:  w_taken = bus.alu_ltu;
      3'b111:  w_taken = !bus.alu_ltu;
      default: w_branchOk = 1'b0;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    w_memReq    = 1'b0;
    w_memWrite  = 1'b0;
    w_adrSrc    = 1'b0;
    w_irWrite   = 1'b0;
    w_pcWrite   = 1'b0;
    w_regWrite  = 1'b0;
    w_resultSrc = c_resAluOut;
    w_srcA      = c_srcAPc;
    w_srcB      = c_srcBRs2;
    w_mode      = MODE_ADD;
    w_mduStart  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memReq    = 1'b1;
        w_srcB      = c_srcBFour;
        w_resultSrc = c_resAluRes;
        w_irWrite   = bus.mem_ready;
        w_pcWrite   = bus.mem_ready;
        if (bus.mem_ready) w_stateNext = S_DECODE;
      end
      S_DECODE: begin
        w_srcA = c_srcAOldPc;
        w_srcB = c_srcBImm;
        case (w_opcode)
          c_opLoad, c_opStore: w_stateNext = S_MEMADR;
          c_opOp: begin
            if (w_funct7 == c_funct7Mdu)
              w_stateNext = (M_EXT != 0) ? S_MDU_WAIT : S_TRAP;
            else
              w_stateNext = S_EXEC_R;
          end
          c_opOpImm:  w_stateNext = S_EXEC_I;
          c_opBranch: w_stateNext = S_BRANCH;
          c_opJal:    w_stateNext = S_JAL;
          c_opJalr:   w_stateNext = S_JALR;
          c_opLui:    w_stateNext = S_LUI;
          c_opAuipc:  w_stateNext = S_ALUWB;
          default:    w_stateNext = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_srcA      = c_srcARs1;
        w_srcB      = c_srcBImm;
        w_stateNext = (w_opcode == c_opStore) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_memReq = 1'b1;
        w_adrSrc = 1'b1;
        if (bus.mem_ready) w_stateNext = S_MEMWB;
      end
      S_MEMWB: begin
        w_regWrite  = 1'b1;
        w_resultSrc = c_resLoad;
        w_stateNext = S_FETCH;
      end
      S_MEMWRITE: begin
        w_memReq   = 1'b1;
        w_memWrite = 1'b1;
        w_adrSrc   = 1'b1;
        if (bus.mem_ready) w_stateNext = S_FETCH;
      end
      S_EXEC_R: begin
        w_srcA      = c_srcARs1;
        w_mode      = MODE_R;
        w_stateNext = S_ALUWB;
      end
      S_EXEC_I: begin
        w_srcA      = c_srcARs1;
        w_srcB      = c_srcBImm;
        w_mode      = MODE_I;
        w_stateNext = S_ALUWB;
      end
      S_ALUWB: begin
        w_regWrite  = 1'b1;
        w_stateNext = S_FETCH;
      end
      S_BRANCH: begin
        w_srcA      = c_srcARs1;
        w_mode      = MODE_SUB;
        w_pcWrite   = w_taken && w_branchOk;
        w_stateNext = w_branchOk ? S_FETCH : S_TRAP;
      end
      S_JAL: begin
        // PC loads the DECODE-computed target from ALUOut while OldPC+4 is formed
        w_srcA      = c_srcAOldPc;
        w_srcB      = c_srcBFour;
        w_pcWrite   = 1'b1;
        w_stateNext = S_ALUWB;
      end
      S_JALR: begin
        w_srcA      = c_srcARs1;
        w_srcB      = c_srcBImm;
        w_resultSrc = c_resAluRes;
        w_pcWrite   = 1'b1;
        w_stateNext = S_ALUWB;
      end
      S_LUI: begin
        w_srcA      = c_srcAZero;
        w_srcB      = c_srcBImm;
        w_stateNext = S_ALUWB;
      end
      S_MDU_WAIT: begin
        w_mduStart = !r_mduBusy;
        if (bus.mdu_done) begin
          w_regWrite  = 1'b1;
          w_resultSrc = c_resMdu;
          w_stateNext = S_FETCH;
        end
      end
      S_TRAP:  w_stateNext = S_TRAP;
      default: w_stateNext = S_TRAP;
    endcase
  end

  alu_op_dec #(
    .ALUCTR_W (ALUCTR_W)
  ) u_aluOpDec (
    .funct3   (w_funct3),
    .funct7b5 (bus.instr[30]),
    .mode     (w_mode),
    .aluCtr   (w_aluCtr)
  );

  assign bus.mem_req    = w_memReq;
  assign bus.mem_write  = w_memWrite;
  assign bus.adr_src    = w_adrSrc;
  assign bus.ir_write   = w_irWrite;
  assign bus.pc_write   = w_pcWrite;
  assign bus.reg_write  = w_regWrite;
  assign bus.result_src = w_resultSrc;
  assign bus.alu_src_a  = w_srcA;
  assign bus.alu_src_b  = w_srcB;
  assign bus.alu_ctr    = w_aluCtr;
  assign bus.mdu_start  = w_mduStart;
  assign bus.illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// tb_mc_ctrl_fsm : scoreboard bench for mc_ctrl_fsm (M_EXT=1 and M_EXT=0)
// Revision       : 1.0
// ============================================================================
module tb_mc_ctrl_fsm;

  localparam int X = -1;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        aluZero;
  logic        aluLt;
  logic        aluLtu;
  logic        memReady;
  logic        mduDone;

  mc_ctrl_if #(.ALUCTR_W(4)) bus0 ();
  mc_ctrl_if #(.ALUCTR_W(4)) bus1 ();

  assign bus0.instr     = instr;
  assign bus0.alu_zero  = aluZero;
  assign bus0.alu_lt    = aluLt;
  assign bus0.alu_ltu   = aluLtu;
  assign bus0.mem_ready = memReady;
  assign bus0.mdu_done  = mduDone;
  assign bus1.instr     = instr;
  assign bus1.alu_zero  = aluZero;
  assign bus1.alu_lt    = aluLt;
  assign bus1.alu_ltu   = aluLtu;
  assign bus1.mem_ready = memReady;
  assign bus1.mdu_done  = mduDone;

  mc_ctrl_fsm #(.M_EXT(0), .ALUCTR_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mc_ctrl_fsm #(.M_EXT(1), .ALUCTR_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Field layout: memReq0 memWrite1 adrSrc2 irWrite3 pcWrite4 regWrite5
  // resultSrc7:6 srcA9:8 srcB11:10 aluCtr15:12 mduStart16 illegal17
  int fL[12] = '{0, 1, 2, 3, 4, 5, 6, 8, 10, 12, 16, 17};
  int fW[12] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 4, 1, 1};

  logic [17:0] expQ[$];
  logic [17:0] mskQ[$];
  int          selQ[$];
  string       tagQ[$];
  int          nChecks = 0;
  int          nErrors = 0;

  function automatic logic [17:0] actOf(input int sel);
    if (sel == 0)
      return {bus0.illegal, bus0.mdu_start, bus0.alu_ctr, bus0.alu_src_b, bus0.alu_src_a,
              bus0.result_src, bus0.reg_write, bus0.pc_write, bus0.ir_write, bus0.adr_src,
              bus0.mem_write, bus0.mem_req};
    return {bus1.illegal, bus1.mdu_start, bus1.alu_ctr, bus1.alu_src_b, bus1.alu_src_a,
            bus1.result_src, bus1.reg_write, bus1.pc_write, bus1.ir_write, bus1.adr_src,
            bus1.mem_write, bus1.mem_req};
  endfunction

  task automatic pushExp(input string tag, input int sel,
                         input int mr, input int mw, input int as, input int iw,
                         input int pw, input int rw, input int rs, input int sa,
                         input int sb, input int ac, input int ms, input int il);
    int v[12];
    int e32;
    int m32;
    v   = '{mr, mw, as, iw, pw, rw, rs, sa, sb, ac, ms, il};
    e32 = 0;
    m32 = 0;
    for (int i = 0; i < 12; i++) begin
      if (v[i] >= 0) begin
        m32 = m32 | (((1 << fW[i]) - 1) << fL[i]);
        e32 = e32 | ((v[i] & ((1 << fW[i]) - 1)) << fL[i]);
      end
    end
    expQ.push_back(e32[17:0]);
    mskQ.push_back(m32[17:0]);
    selQ.push_back(sel);
    tagQ.push_back(tag);
  endtask

  task automatic expFetch(input string t, input int s, input int mr);
    pushExp(t, s, 1, 0, 0, mr, mr, 0, 2, 0, 2, 0, 0, 0);
  endtask
  task automatic expDecode(input string t, input int s);
    pushExp(t, s, 0, 0, X, 0, 0, 0, X, 1, 1, 0, 0, 0);
  endtask
  task automatic expExecR(input string t, input int s, input int ac);
    pushExp(t, s, 0, 0, X, 0, 0, 0, X, 2, 0, ac, 0, 0);
  endtask
  task automatic expAluWb(input string t, input int s);
    pushExp(t, s, 0, 0, X, 0, 0, 1, 0, X, X, X, 0, 0);
  endtask
  task automatic expMemAdr(input string t, input int s);
    pushExp(t, s, 0, 0, X, 0, 0, 0, X, 2, 1, 0, 0, 0);
  endtask
  task automatic expMemRead(input string t, input int s);
    pushExp(t, s, 1, 0, 1, 0, 0, 0, X, X, X, X, 0, 0);
  endtask
  task automatic expMemWb(input string t, input int s);
    pushExp(t, s, 0, 0, X, 0, 0, 1, 1, X, X, X, 0, 0);
  endtask
  task automatic expBranch(input string t, input int s, input int pw);
    pushExp(t, s, 0, 0, X, 0, pw, 0, 0, 2, 0, 1, 0, 0);
  endtask
  task automatic expMdu(input string t, input int s, input int st, input int dn);
    pushExp(t, s, 0, 0, X, 0, 0, dn, (dn != 0) ? 3 : X, X, X, X, st, 0);
  endtask
  task automatic expTrap(input string t, input int s);
    pushExp(t, s, 0, 0, X, 0, 0, 0, X, X, X, X, 0, 1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares every expectation queued for this cycle
  logic [17:0] mE;
  logic [17:0] mM;
  logic [17:0] mA;
  int          mS;
  string       mT;
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      mE = expQ.pop_front();
      mM = mskQ.pop_front();
      mS = selQ.pop_front();
      mT = tagQ.pop_front();
      mA = actOf(mS);
      nChecks++;
      if (((mA ^ mE) & mM) !== 18'h0) begin
        nErrors++;
        $display("FAIL %s dut%0d: got %05h required %05h (care mask %05h) at %0t",
                 mT, mS, mA, mE & mM, mM, $time);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    instr    = 32'h0;
    aluZero  = 1'b0;
    aluLt    = 1'b0;
    aluLtu   = 1'b0;
    memReady = 1'b0;
    mduDone  = 1'b0;
    step;
    step;

    // add x3,x1,x2
    rst_n = 1'b1; memReady = 1'b1; instr = 32'h002081B3;
    expFetch("reset_fetch", 0, 1); expFetch("add_fetch", 1, 1); step;
    expDecode("add_decode", 1); step;
    expExecR("add_exec_r", 1, 0); step;
    expAluWb("add_aluwb", 1); step;

    // lw with three wait states in MEMREAD
    instr = 32'h0000A183;
    expFetch("lw_fetch", 1, 1); step;
    expDecode("lw_decode", 1); step;
    expMemAdr("lw_memadr", 1); step;
    memReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expMemRead("lw_memread_wait", 1); step;
    end
    memReady = 1'b1; expMemRead("lw_memread_done", 1); step;
    memReady = 1'b0; expMemWb("lw_memwb", 1); step;

    // reset asserted for two cycles in the middle of MEMREAD
    memReady = 1'b1;
    expFetch("rst_lw_fetch", 1, 1); step;
    expDecode("rst_lw_decode", 1); step;
    expMemAdr("rst_lw_memadr", 1); step;
    memReady = 1'b0; expMemRead("rst_lw_memread", 1); step;
    rst_n = 1'b0; expMemRead("rst_low_first", 1); step;
    expFetch("rst_low_second", 1, 0); step;
    rst_n = 1'b1; expFetch("rst_recover", 1, 0); expFetch("rst_recover", 0, 0); step;

    // bne not taken, then taken
    instr = 32'h00209463; memReady = 1'b1; aluZero = 1'b1;
    expFetch("bne_nt_fetch", 1, 1); step;
    expDecode("bne_nt_decode", 1); step;
    expBranch("bne_not_taken", 1, 0); step;
    aluZero = 1'b0;
    expFetch("bne_t_fetch", 1, 1); step;
    expDecode("bne_t_decode", 1); step;
    expBranch("bne_taken", 1, 1); step;

    // mul: MDU on dut1, illegal on dut0
    instr = 32'h022081B3;
    expFetch("mul_fetch", 1, 1); expFetch("mul_fetch", 0, 1); step;
    expDecode("mul_decode", 1); expDecode("mul_decode", 0); step;
    for (int k = 1; k <= 5; k++) begin
      mduDone = (k == 5);
      expMdu("mul_mdu_wait", 1, (k == 1) ? 1 : 0, (k == 5) ? 1 : 0);
      expTrap("mul_no_mext_trap", 0);
      step;
    end
    mduDone = 1'b0;

    // stray mdu_done in DECODE, then done coinciding with start
    expFetch("mul2_fetch", 1, 1); expTrap("mul2_trap_held", 0); step;
    mduDone = 1'b1;
    expDecode("stray_done_decode", 1); expTrap("mul2_trap_held", 0); step;
    expMdu("mul2_done_with_start", 1, 1, 1); expTrap("mul2_trap_held", 0); step;
    mduDone = 1'b0;

    // unknown opcode 0x7F
    instr = 32'h0000007F;
    expFetch("op7f_fetch", 1, 1); expTrap("op7f_trap_held", 0); step;
    expDecode("op7f_decode", 1); expTrap("op7f_trap_held", 0); step;
    for (int k = 0; k < 10; k++) begin
      memReady = k[0];
      mduDone  = k[1];
      expTrap("op7f_trap", 1); expTrap("op7f_trap_held", 0); step;
    end
    memReady = 1'b1; mduDone = 1'b0;
    rst_n = 1'b0; expTrap("trap_before_rst_edge", 1); step;
    rst_n = 1'b1;
    expFetch("trap_recover", 1, 1); expFetch("trap_recover", 0, 1); step;

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
